// File: rtl/conv3x3_window_stream_if.sv
// Pixel-in / window-out stream bundle for conv3x3_window_stream.
// The master drives pixels and accepts windows; the slave is the window generator.
interface conv3x3_window_stream_if #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PX_W  = 8
);
  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic                in_valid;
  logic                in_ready;
  logic [PX_W-1:0]     in_px;
  logic                win_valid;
  logic                win_ready;
  logic [9*PX_W-1:0]   win_px;
  logic [XW-1:0]       win_x;
  logic [YW-1:0]       win_y;

  modport master (
    output in_valid, in_px, win_ready,
    input  in_ready, win_valid, win_px, win_x, win_y
  );

  modport slave (
    input  in_valid, in_px, win_ready,
    output in_ready, win_valid, win_px, win_x, win_y
  );
endinterface

// File: rtl/conv3x3_window_stream.sv
// Raster-stream 3x3 window generator: two line buffers plus a 3x3 shift window, border padded.
// Define REPLICATE_PAD_EN for edge-replicate padding; zero padding otherwise.
module conv3x3_window_stream #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int PX_W  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic frame_done,
  conv3x3_window_stream_if.slave s
);
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);
  localparam int NPIX = IMG_W * IMG_H;
  localparam int CW   = $clog2(NPIX + 1);
  localparam int FW   = $clog2(IMG_W + 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_FLUSH = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     pix_cnt_q, pix_cnt_d;
  logic [FW-1:0]     inj_cnt_q, inj_cnt_d;
  logic [XW-1:0]     col_q, col_d;
  logic [XW-1:0]     gen_x_q, gen_x_d, win_x_q, win_x_d;
  logic [YW-1:0]     gen_y_q, gen_y_d, win_y_q, win_y_d;
  logic              win_valid_q, win_valid_d;
  logic              frame_done_q, frame_done_d;
  logic [9*PX_W-1:0] win_px_q, win_px_d, win_px_new;
  logic [PX_W-1:0]   tap_q [3][3];
  logic [PX_W-1:0]   tap_d [3][3];
  logic [PX_W-1:0]   line0 [IMG_W];
  logic [PX_W-1:0]   line1 [IMG_W];

  logic slot_free, accept, inject, shift, emit, last_hs;
  logic lft_m, rgt_m, top_m, bot_m;
  logic [PX_W-1:0] px_new;

  always_comb begin
    slot_free  = !win_valid_q || s.win_ready;
    s.in_ready = (state_q == S_FILL || state_q == S_RUN) && slot_free;
    accept     = s.in_valid && s.in_ready;
    inject     = (state_q == S_FLUSH) && slot_free && (inj_cnt_q != FW'(IMG_W + 1));
    shift      = accept || inject;
    emit       = (state_q == S_RUN && accept) || inject;
    px_new     = inject ? '0 : s.in_px;
    last_hs    = (state_q == S_FLUSH) && win_valid_q && s.win_ready &&
                 (win_x_q == XW'(IMG_W - 1)) && (win_y_q == YW'(IMG_H - 1));
    lft_m      = (gen_x_q == '0);
    rgt_m      = (gen_x_q == XW'(IMG_W - 1));
    top_m      = (gen_y_q == '0);
    bot_m      = (gen_y_q == YW'(IMG_H - 1));
  end

  // New column entering on the right: two rows up, one row up, incoming pixel.
  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        tap_d[r][c] = tap_q[r][c];
    if (shift) begin
      for (int r = 0; r < 3; r++) begin
        tap_d[r][0] = tap_q[r][1];
        tap_d[r][1] = tap_q[r][2];
      end
      tap_d[0][2] = line1[col_q];
      tap_d[1][2] = line0[col_q];
      tap_d[2][2] = px_new;
    end
  end

`ifdef REPLICATE_PAD_EN
  function automatic logic [1:0] src_idx(input int i, input logic lo, input logic hi);
    return ((i == 0 && lo) || (i == 2 && hi)) ? 2'd1 : 2'(i);
  endfunction
`endif

  // Wrapped-row and pre-frame taps only ever land in masked positions.
  always_comb begin
    win_px_new = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
`ifdef REPLICATE_PAD_EN
        win_px_new[(r*3+c)*PX_W +: PX_W] = tap_d[src_idx(r, top_m, bot_m)][src_idx(c, lft_m, rgt_m)];
`else
        if (!((c == 0 && lft_m) || (c == 2 && rgt_m) || (r == 0 && top_m) || (r == 2 && bot_m)))
          win_px_new[(r*3+c)*PX_W +: PX_W] = tap_d[r][c];
`endif
      end
  end

  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    inj_cnt_d    = inj_cnt_q;
    col_d        = col_q;
    gen_x_d      = gen_x_q;
    gen_y_d      = gen_y_q;
    win_x_d      = win_x_q;
    win_y_d      = win_y_q;
    win_px_d     = win_px_q;
    frame_done_d = last_hs;
    win_valid_d  = emit ? 1'b1 : (s.win_ready ? 1'b0 : win_valid_q);

    if (accept) pix_cnt_d = pix_cnt_q + CW'(1);
    if (inject) inj_cnt_d = inj_cnt_q + FW'(1);
    if (shift)  col_d = (col_q == XW'(IMG_W - 1)) ? '0 : col_q + XW'(1);
    if (emit) begin
      win_px_d = win_px_new;
      win_x_d  = gen_x_q;
      win_y_d  = gen_y_q;
      if (gen_x_q == XW'(IMG_W - 1)) begin
        gen_x_d = '0;
        gen_y_d = (gen_y_q == YW'(IMG_H - 1)) ? '0 : gen_y_q + YW'(1);
      end else begin
        gen_x_d = gen_x_q + XW'(1);
      end
    end

    case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_FILL;
        pix_cnt_d = '0;
        inj_cnt_d = '0;
        col_d     = '0;
        gen_x_d   = '0;
        gen_y_d   = '0;
      end
      S_FILL:  if (accept && pix_cnt_q == CW'(IMG_W)) state_d = S_RUN;
      S_RUN:   if (accept && pix_cnt_q == CW'(NPIX - 1)) state_d = S_FLUSH;
      default: if (last_hs) state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      pix_cnt_q    <= '0;
      inj_cnt_q    <= '0;
      col_q        <= '0;
      gen_x_q      <= '0;
      gen_y_q      <= '0;
      win_x_q      <= '0;
      win_y_q      <= '0;
      win_px_q     <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          tap_q[r][c] <= '0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      inj_cnt_q    <= inj_cnt_d;
      col_q        <= col_d;
      gen_x_q      <= gen_x_d;
      gen_y_q      <= gen_y_d;
      win_x_q      <= win_x_d;
      win_y_q      <= win_y_d;
      win_px_q     <= win_px_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          tap_q[r][c] <= tap_d[r][c];
    end
  end

  always_ff @(posedge clk) begin
    if (shift) begin
      line1[col_q] <= line0[col_q];
      line0[col_q] <= px_new;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign frame_done  = frame_done_q;
  assign s.win_valid = win_valid_q;
  assign s.win_px    = win_px_q;
  assign s.win_x     = win_x_q;
  assign s.win_y     = win_y_q;
endmodule

// File: doc/conv3x3_window_stream.md
Name: conv3x3_window_stream

Overview:
Parametrised raster-stream 3x3 window generator, the next-generation front end for the blur/Sobel layers. It replaces nine-address random memory reads with one pixel per handshake plus two internal line buffers. It emits one 9-tap window per image pixel, with border padding and valid/ready back-pressure. The output drives any 3x3 kernel (Gaussian, median, Sobel) directly.

Parameters:
IMG_W, 64, image width in pixels (>=3)
IMG_H, 64, image height in pixels (>=3)
PX_W, 8, pixel bit width

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; begins a frame (ignored while busy)
busy  out  1  high from the cycle after start until frame_done
in_valid  in  1  input pixel valid
in_ready  out  1  block accepts in_px this cycle
in_px  in  PX_W  input pixel, raster order (row 0 col 0 first)
win_valid  out  1  window valid
win_ready  in  1  consumer accepts window
win_px  out  9*PX_W  taps 1..9 = TL,T,TR,L,C,R,BL,B,BR; tap1 in LSBs
win_x  out  clog2(IMG_W)  window centre column
win_y  out  clog2(IMG_H)  window centre row
frame_done  out  1  one-cycle pulse on acceptance of window (IMG_W-1,IMG_H-1)

Behaviour:
- Reset: state IDLE; busy, in_ready, win_valid, frame_done = 0; win_px, win_x, win_y = 0; counters = 0. Line-buffer contents are don't-care because masking hides them.
- States:
  - IDLE: start -> FILL.
  - FILL: accept the first IMG_W+1 pixels, no windows emitted -> RUN.
  - RUN: each accept emits one window -> FLUSH after the accept of pixel IMG_W*IMG_H-1.
  - FLUSH: in_ready=0; inject IMG_W+1 virtual zero pixels, one per cycle in which the output slot is free -> IDLE on frame_done.
- in_ready = (state==FILL || state==RUN) && (!win_valid || win_ready).
- Accept = in_valid && in_ready.
- Window k (raster index, centre x=k%IMG_W, y=k/IMG_W) is generated by the accept of input k+IMG_W+1, or by FLUSH step k+IMG_W+1-IMG_W*IMG_H.
- Latency: win_valid rises the cycle after the triggering accept/injection.
- Output register: win_px/win_x/win_y are held stable while win_valid && !win_ready.
- Pipeline: 2 line buffers of IMG_W x PX_W plus a 3x3 shift window; one shift per accept/injection only.
- Padding: taps outside the image are forced to 0:
  - x==0 masks the left column.
  - x==IMG_W-1 masks the right column (this also masks wrap-around from the adjacent row).
  - y==0 masks the top row.
  - y==IMG_H-1 masks the bottom row.
- Total windows per frame = IMG_W*IMG_H exactly. win_x/win_y wrap at IMG_W-1 / IMG_H-1.
- start while busy: ignored. in_valid outside FILL/RUN: ignored.
- frame_done and the return of busy to 0 occur in the cycle after the last window handshake. A new start is legal from the following cycle.
- Reset mid-frame: immediate return to reset values. A partial frame is discarded and no frame_done is issued.

Optional Feature:
REPLICATE_PAD_EN: when defined, out-of-image taps take the nearest in-image pixel instead of 0:
- Left column copies the centre column; right column copies the centre column.
- Top row copies the middle row; bottom row copies the middle row.
- Corners apply both rules.

When undefined, zero padding is used, as above.

Test Plan:
- IMG_W=4, IMG_H=3, PX_W=8, ramp input 1..12, win_ready=1 -> window (0,0) = [0,0,0,0,1,2,0,5,6]; (1,1) = [1,2,3,5,6,7,9,10,11]; (3,2) = [7,8,0,11,12,0,0,0,0]; exactly 12 windows, frame_done one pulse.
- Same frame, win_ready low 5 cycles at window (2,1) -> win_px = [2,3,4,6,7,8,10,11,12] held stable; in_ready=0 during the stall; no pixel lost or duplicated.
- in_valid toggled 1/0 every cycle -> windows identical to the first test; first win_valid one cycle after the accept of pixel 6.
- Reset asserted after 7 accepts, then start -> fresh frame output matches the first test; no stale frame_done.
- start pulsed while busy -> ignored; frame completes normally with 12 windows.
- REPLICATE_PAD_EN defined, ramp 1..12 -> window (0,0) = [1,1,2,1,1,2,5,5,6]; (3,2) = [7,8,8,11,12,12,11,12,12].
